// File: rtl/ccff_loader_pkg.sv
// ---------------------------------------------------------------------------
// ccff_loader_pkg: shared state encoding and CRC-8 helper for the ccff loader.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RB   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // MSB-first serial CRC-8 update for one bit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return fb ? ((crc << 1) ^ CRC8_POLY) : (crc << 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ccff_word_serializer.sv
// ---------------------------------------------------------------------------
// ccff_word_serializer: holding register + MSB-first shift register feeding
// one bit per take; reloads from holding on the last bit so streaming is gapless.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ccff_word_serializer #(
  parameter int WORD_W  = 8,
  parameter int N_WORDS = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              clear,
  input  logic              active,
  input  logic              take,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              bit_avail,
  output logic              bit_val
);
  localparam int SC_W = $clog2(WORD_W + 1);
  localparam int WA_W = $clog2(N_WORDS + 1);

  logic [WORD_W-1:0] hold_q, hold_d, sh_q, sh_d;
  logic              hold_vld_q, hold_vld_d;
  logic [SC_W-1:0]   sh_cnt_q, sh_cnt_d;
  logic [WA_W-1:0]   words_q, words_d;
  logic              accept;

  assign bs_ready  = active && !hold_vld_q && (words_q < WA_W'(N_WORDS));
  assign accept    = bs_ready && bs_valid;
  assign bit_avail = (sh_cnt_q != '0) || hold_vld_q;
  // An empty shifter issues straight from holding so the first bit loses no cycle.
  assign bit_val   = (sh_cnt_q != '0) ? sh_q[WORD_W-1] : hold_q[WORD_W-1];

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    sh_d       = sh_q;
    sh_cnt_d   = sh_cnt_q;
    words_d    = words_q;
    if (take) begin
      if (sh_cnt_q == '0) begin
        sh_d       = hold_q << 1;
        sh_cnt_d   = SC_W'(WORD_W - 1);
        hold_vld_d = 1'b0;
      end else if (sh_cnt_q == SC_W'(1) && hold_vld_q) begin
        sh_d       = hold_q;
        sh_cnt_d   = SC_W'(WORD_W);
        hold_vld_d = 1'b0;
      end else begin
        sh_d     = sh_q << 1;
        sh_cnt_d = sh_cnt_q - 1'b1;
      end
    end
    if (accept) begin
      hold_d     = bs_data;
      hold_vld_d = 1'b1;
      words_d    = words_q + 1'b1;
    end
    if (clear) begin
      hold_d     = '0;
      hold_vld_d = 1'b0;
      sh_d       = '0;
      sh_cnt_d   = '0;
      words_d    = '0;
    end
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      sh_q       <= '0;
      sh_cnt_q   <= '0;
      words_q    <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      sh_q       <= sh_d;
      sh_cnt_q   <= sh_cnt_d;
      words_q    <= words_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader: serialises bitstream words onto a ccff chain head.
// Optional tail readback with CRC-8 compare when CCFF_READBACK_EN is defined.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int CNT_W   = $clog2(CHAIN_LEN + 1);
  localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             head_q, head_d, clk_en_q, clk_en_d;
  logic             bit_avail, bit_val, take, ser_clear;

`ifdef CCFF_READBACK_EN
  logic [CNT_W-1:0] rb_cnt_q, rb_cnt_d;
  logic [7:0]       crc_load_q, crc_load_d, crc_tail_q, crc_tail_d;
  logic             err_q, err_d;
`endif

  assign ser_clear = start && (state_q == IDLE || state_q == DONE);
  assign take      = (state_q == LOAD) && (bit_cnt_q != CNT_W'(CHAIN_LEN)) && bit_avail;

  ccff_word_serializer #(
    .WORD_W  (WORD_W),
    .N_WORDS (N_WORDS)
  ) u_ser (
    .prog_clk   (prog_clk),
    .prog_reset (prog_reset),
    .clear      (ser_clear),
    .active     (state_q == LOAD),
    .take       (take),
    .bs_data    (bs_data),
    .bs_valid   (bs_valid),
    .bs_ready   (bs_ready),
    .bit_avail  (bit_avail),
    .bit_val    (bit_val)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    head_d    = head_q;
    clk_en_d  = 1'b0;
`ifdef CCFF_READBACK_EN
    rb_cnt_d   = rb_cnt_q;
    crc_load_d = crc_load_q;
    crc_tail_d = crc_tail_q;
    err_d      = err_q;
`endif
    // A starved cycle leaves ccff_head untouched and gates the chain clock.
    if (take) begin
      head_d    = bit_val;
      clk_en_d  = 1'b1;
      bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef CCFF_READBACK_EN
      crc_load_d = crc8_step(crc_load_q, bit_val);
`endif
    end
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = LOAD;
          bit_cnt_d = '0;
`ifdef CCFF_READBACK_EN
          rb_cnt_d   = '0;
          crc_load_d = 8'h00;
          crc_tail_d = 8'h00;
          err_d      = 1'b0;
`endif
        end
      end
      LOAD: begin
        if (bit_cnt_q == CNT_W'(CHAIN_LEN)) begin
`ifdef CCFF_READBACK_EN
          state_d = RB;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef CCFF_READBACK_EN
      RB: begin
        crc_tail_d = crc8_step(crc_tail_q, ccff_tail);
        rb_cnt_d   = rb_cnt_q + 1'b1;
        if (rb_cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
          state_d = DONE;
          err_d   = (crc_load_q != crc8_step(crc_tail_q, ccff_tail));
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      head_q    <= 1'b0;
      clk_en_q  <= 1'b0;
`ifdef CCFF_READBACK_EN
      rb_cnt_q   <= '0;
      crc_load_q <= 8'h00;
      crc_tail_q <= 8'h00;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      head_q    <= head_d;
      clk_en_q  <= clk_en_d;
`ifdef CCFF_READBACK_EN
      rb_cnt_q   <= rb_cnt_d;
      crc_load_q <= crc_load_d;
      crc_tail_q <= crc_tail_d;
      err_q      <= err_d;
`endif
    end
  end

`ifdef CCFF_READBACK_EN
  // Readback rotates the chain: tail loops straight back to head every cycle.
  assign ccff_head   = (state_q == RB) ? ccff_tail : head_q;
  assign ccff_clk_en = clk_en_q || (state_q == RB);
  assign err         = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign ccff_head   = head_q;
  assign ccff_clk_en = clk_en_q;
  assign err         = 1'b0;
`endif

  assign busy = (state_q == LOAD) || (state_q == RB);
  assign done = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_bitstream_loader: directed/random loads on 64- and 20-bit chains,
// checked against a bit-queue reference and a behavioural chain model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ccff_bitstream_loader;

  logic        prog_clk   = 1'b0;
  logic        prog_reset = 1'b1;
  logic        start      = 1'b0;
  logic [7:0]  bs_data    = 8'h00;
  logic        bs_valid   = 1'b0;
  logic        sel20      = 1'b0;
  logic        flip_now   = 1'b0;
  logic [63:0] chain      = 64'h0;
  int          cur_len    = 64;
  int          n_cmp      = 0;
  int          n_bad      = 0;

  logic ccff_tail, start64, start20;
  logic rdy64, head64, cen64, busy64, done64, err64;
  logic rdy20, head20, cen20, busy20, done20, err20;
  logic bs_ready, ccff_head, ccff_clk_en, busy, done, err;

  assign start64     = start & ~sel20;
  assign start20     = start & sel20;
  assign bs_ready    = sel20 ? rdy20  : rdy64;
  assign ccff_head   = sel20 ? head20 : head64;
  assign ccff_clk_en = sel20 ? cen20  : cen64;
  assign busy        = sel20 ? busy20 : busy64;
  assign done        = sel20 ? done20 : done64;
  assign err         = sel20 ? err20  : err64;

  ccff_bitstream_loader #(.CHAIN_LEN(64), .WORD_W(8)) dut64 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start64),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(rdy64),
    .ccff_head(head64), .ccff_clk_en(cen64), .ccff_tail(ccff_tail),
    .busy(busy64), .done(done64), .err(err64)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut20 (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start20),
    .bs_data(bs_data), .bs_valid(bs_valid), .bs_ready(rdy20),
    .ccff_head(head20), .ccff_clk_en(cen20), .ccff_tail(ccff_tail),
    .busy(busy20), .done(done20), .err(err20)
  );

  always #5 prog_clk = ~prog_clk;

  // Behavioural chain: shifts head in on every enabled cycle, tail is the far end.
  always @(posedge prog_clk) if (ccff_clk_en) chain <= {chain[62:0], ccff_head ^ flip_now};
  assign ccff_tail = chain[6'(cur_len - 1)];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bs_ready"}, 64'(bs_ready), 64'(0));
    chk({tag, "_ccff_head"}, 64'(ccff_head), 64'(0));
    chk({tag, "_ccff_clk_en"}, 64'(ccff_clk_en), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done"}, 64'(done), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
  endtask

  task automatic run_load(input bit use20, input bit fixed_pat, input int gap_at,
                          input int gap_len, input int poke_at, input int rst_at,
                          input bit flip);
    logic [7:0]  words[$];
    bit          exp_bits[$];
    logic [7:0]  w;
    logic [63:0] exp_chain, mask;
    logic        last_head;
    int clen, nw, wi, en_cnt, stalls, first_acc, first_en, last_en, done_cyc, gap_left, exp_en;
    bit seen_done, gap_done;

    sel20   = use20;
    cur_len = use20 ? 20 : 64;
    clen    = cur_len;
    nw      = (clen + 7) / 8;
    for (int i = 0; i < nw; i++) begin
      w = fixed_pat ? 8'(8'hA5 + i) : 8'($urandom);
      words.push_back(w);
      for (int b = 7; b >= 0; b--) if (exp_bits.size() < clen) exp_bits.push_back(w[b]);
    end
`ifdef CCFF_READBACK_EN
    exp_en = 2 * clen;
`else
    exp_en = clen;
`endif

    @(negedge prog_clk);
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;

    wi = 0; en_cnt = 0; stalls = 0; first_acc = -1; first_en = -1; last_en = -1;
    done_cyc = -1; gap_left = 0; seen_done = 0; gap_done = 0; last_head = ccff_head;
    for (int cyc = 0; cyc < 600 && !seen_done; cyc++) begin
      if (cyc == 0) chk("busy_in_load", 64'(busy), 64'(1));
      if (ccff_clk_en) begin
        if (en_cnt < clen) chk("stream_bit", 64'(ccff_head), 64'(exp_bits[en_cnt]));
        else if (en_cnt < 2 * clen && !flip)
          chk("readback_bit", 64'(ccff_head), 64'(exp_bits[en_cnt - clen]));
        if (first_en < 0) first_en = cyc;
        en_cnt++;
        last_en = cyc;
      end else if (en_cnt > 0 && en_cnt < clen) begin
        chk("stall_head_held", 64'(ccff_head), 64'(last_head));
        stalls++;
      end
      last_head = ccff_head;
      flip_now  = flip && ccff_clk_en && (en_cnt == 10);
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
      end

      if (rst_at >= 0 && en_cnt == rst_at) begin
        prog_reset = 1'b1;
        bs_valid   = 1'b0;
        #1;
        chk_reset_outputs("midload_reset");
        @(negedge prog_clk);
        prog_reset = 1'b0;
        flip_now   = 1'b0;
        return;
      end

      if (!seen_done) begin
        start = (cyc == poke_at);
        if (wi >= nw) chk("no_extra_word", 64'(bs_ready), 64'(0));
        if (gap_at >= 0 && cyc >= gap_at && !gap_done && bs_ready && wi < nw) begin
          gap_left = gap_len;
          gap_done = 1;
        end
        bs_valid = (wi < nw) && (gap_left == 0);
        bs_data  = (wi < nw) ? words[wi] : 8'h00;
        if (gap_left > 0) gap_left--;
        if (bs_valid && bs_ready) begin
          if (first_acc < 0) first_acc = cyc;
          wi++;
        end
        @(negedge prog_clk);
      end
    end
    start    = 1'b0;
    bs_valid = 1'b0;
    flip_now = 1'b0;

    chk("done_seen", 64'(seen_done), 64'(1));
    chk("words_accepted", 64'(wi), 64'(nw));
    chk("first_bit_latency", 64'(first_en - first_acc), 64'(2));
    chk("enabled_count", 64'(en_cnt), 64'(exp_en));
    chk("done_after_last_enable", 64'(done_cyc - last_en), 64'(1));
    chk("starved_cycles", 64'(stalls), 64'(gap_len > 0 ? gap_len - 7 : 0));
    chk("busy_at_done", 64'(busy), 64'(0));
    chk("err_at_done", 64'(err), 64'(flip));
    exp_chain = '0;
    mask      = '0;
    for (int i = 0; i < clen; i++) begin
      exp_chain[clen - 1 - i] = exp_bits[i];
      mask[i] = 1'b1;
    end
    if (!flip) chk("chain_contents", chain & mask, exp_chain);
  endtask

  initial begin
    #2;
    chk_reset_outputs("reset64");
    sel20 = 1'b1;
    #1;
    chk_reset_outputs("reset20");
    sel20 = 1'b0;
    @(negedge prog_clk);
    prog_reset = 1'b0;

    // 64 bits streamed from eight back-to-back fixed-pattern words
    run_load(1'b0, 1'b1, -1, 0, -1, -1, 1'b0);
    // 20-bit chain: third word only half used
    run_load(1'b1, 1'b0, -1, 0, -1, -1, 1'b0);
    // source starves mid-stream
    run_load(1'b0, 1'b0, 20, 13, -1, -1, 1'b0);
    // reset at bit 30, then a full clean reload
    run_load(1'b0, 1'b0, -1, 0, -1, 30, 1'b0);
    run_load(1'b0, 1'b0, -1, 0, -1, -1, 1'b0);
    // start pulsed while loading
    run_load(1'b0, 1'b0, -1, 0, 15, -1, 1'b0);
`ifdef CCFF_READBACK_EN
    // corrupted chain bit must raise err; next load clears it
    run_load(1'b0, 1'b0, -1, 0, -1, -1, 1'b1);
    run_load(1'b0, 1'b0, -1, 0, -1, -1, 1'b0);
    run_load(1'b1, 1'b0, -1, 0, -1, -1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
